majority_circuit: RTL and testbench

- N-input majority voter; default 5 inputs, x1..x5.
- Provides a combinational majority output `z` for immediate use.
- Provides a registered, valid-qualified copy of the result plus the population count, for pipelined datapaths.
- Used wherever redundant bits are voted into one decision, e.g. TMR/5MR voting or sampled-bit filtering.

---
 rtl/majority_circuit_if.sv | 32 +++
 rtl/majority_circuit.sv | 57 +++++
 tb/tb_majority_circuit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/majority_circuit_if.sv
// Voter bus: the sample vector with its valid qualifier going in, and the
// combinational and registered vote results coming back.
interface majority_circuit_if #(
  parameter int N = 5
) ();
  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  x;
  logic          in_valid;
  logic          z;
  logic          z_q;
  logic [CW-1:0] count_q;
  logic          out_valid;

  modport master (
    output x,
    output in_valid,
    input  z,
    input  z_q,
    input  count_q,
    input  out_valid
  );

  modport slave (
    input  x,
    input  in_valid,
    output z,
    output z_q,
    output count_q,
    output out_valid
  );
endinterface

// File: rtl/majority_circuit.sv
// N-input majority voter: combinational vote plus a valid-qualified registered
// copy of the vote and the popcount for pipelined use.
module majority_circuit #(
  parameter int N      = 5,
  parameter int THRESH = (N + 1) / 2
) (
  input logic              clk,
  input logic              rst,
  majority_circuit_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] THRESH_CW = CW'(THRESH);

  // Reject illegal configurations at elaboration rather than building a voter that ties or never fires.
  if ((N % 2) == 0 || N < 3) begin : g_badN
    $error("majority_circuit: N must be odd and at least 3 (N=%0d)", N);
  end
  if (THRESH < 1 || THRESH > N) begin : g_badThresh
    $error("majority_circuit: THRESH must be in 1..N (THRESH=%0d, N=%0d)", THRESH, N);
  end

  logic [CW-1:0] w_popCount;
  logic          w_vote;

  logic          r_zQ;
  logic [CW-1:0] r_countQ;
  logic          r_outValid;

  always_comb begin
    w_popCount = '0;
    for (int i = 0; i < N; i++) begin
      w_popCount = w_popCount + CW'(bus.x[i]);
    end
  end

  assign w_vote = (w_popCount >= THRESH_CW);

  // Vote and count only update on valid samples; out_valid pulses per accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zQ       <= 1'b0;
      r_countQ   <= '0;
      r_outValid <= 1'b0;
    end else if (bus.in_valid) begin
      r_zQ       <= w_vote;
      r_countQ   <= w_popCount;
      r_outValid <= 1'b1;
    end else begin
      r_outValid <= 1'b0;
    end
  end

  assign bus.z         = w_vote;
  assign bus.z_q       = r_zQ;
  assign bus.count_q   = r_countQ;
  assign bus.out_valid = r_outValid;
endmodule

// File: tb/tb_majority_circuit.sv
// Directed bench for majority_circuit: default 5-input voter, a THRESH=4
// variant sharing its inputs, and a 7-input voter.
module tb_majority_circuit;
  logic       clk;
  logic       rst;
  logic       inValid;
  logic [4:0] x5;
  logic [6:0] x7;

  int checkCount;
  int passCount;

  majority_circuit_if #(.N(5)) if5 ();
  majority_circuit_if #(.N(5)) ifT ();
  majority_circuit_if #(.N(7)) if7 ();

  assign if5.x        = x5;
  assign if5.in_valid = inValid;
  assign ifT.x        = x5;
  assign ifT.in_valid = inValid;
  assign if7.x        = x7;
  assign if7.in_valid = inValid;

  majority_circuit #(.N(5))              dut5 (.clk(clk), .rst(rst), .bus(if5));
  majority_circuit #(.N(5), .THRESH(4))  dutT (.clk(clk), .rst(rst), .bus(ifT));
  majority_circuit #(.N(7))              dut7 (.clk(clk), .rst(rst), .bus(if7));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  // Inputs change right after a falling edge; returning at the next falling edge
  // leaves exactly one rising edge in between, so outputs are sampled mid-cycle.
  task automatic applyStimulus(input logic rstV, input logic validV,
                               input logic [4:0] x5V, input logic [6:0] x7V);
    rst     = rstV;
    inValid = validV;
    x5      = x5V;
    x7      = x7V;
    @(negedge clk);
  endtask

  logic [4:0] spotIdx [6];
  logic       spotZ   [6];

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst        = 1'b1;
    inValid    = 1'b0;
    x5         = '0;
    x7         = '0;
    spotIdx    = '{5'd7, 5'd3, 5'd21, 5'd24, 5'd31, 5'd0};
    spotZ      = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 32; i++) begin
      x5 = 5'(i);
      #10;
      checkOutput($sformatf("sweep z i=%0d", i), 32'(if5.z), 32'($countones(5'(i)) >= 3));
      checkOutput($sformatf("sweepT z i=%0d", i), 32'(ifT.z), 32'($countones(5'(i)) >= 4));
    end

    for (int k = 0; k < 6; k++) begin
      x5 = spotIdx[k];
      #10;
      checkOutput($sformatf("spot z i=%0d", spotIdx[k]), 32'(if5.z), 32'(spotZ[k]));
    end

    x5 = 5'b01110; #10;
    checkOutput("thresh4 z 01110", 32'(ifT.z), 32'd0);
    x5 = 5'b11110; #10;
    checkOutput("thresh4 z 11110", 32'(ifT.z), 32'd1);

    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 5'b00000, 7'b0);
    applyStimulus(1'b1, 1'b0, 5'b00000, 7'b0);
    checkOutput("reset z_q",       32'(if5.z_q),       32'd0);
    checkOutput("reset count_q",   32'(if5.count_q),   32'd0);
    checkOutput("reset out_valid", 32'(if5.out_valid), 32'd0);
    checkOutput("reset7 count_q",  32'(if7.count_q),   32'd0);

    applyStimulus(1'b0, 1'b1, 5'b11010, 7'b0);
    checkOutput("11010 z_q",       32'(if5.z_q),       32'd1);
    checkOutput("11010 count_q",   32'(if5.count_q),   32'd3);
    checkOutput("11010 out_valid", 32'(if5.out_valid), 32'd1);

    applyStimulus(1'b0, 1'b1, 5'b10000, 7'b0);
    checkOutput("10000 z_q",       32'(if5.z_q),       32'd0);
    checkOutput("10000 count_q",   32'(if5.count_q),   32'd1);
    checkOutput("10000 out_valid", 32'(if5.out_valid), 32'd1);

    applyStimulus(1'b0, 1'b1, 5'b11101, 7'b0);
    checkOutput("11101 z_q",     32'(if5.z_q),     32'd1);
    checkOutput("11101 count_q", 32'(if5.count_q), 32'd4);

    applyStimulus(1'b0, 1'b0, 5'b00000, 7'b0);
    checkOutput("hold out_valid", 32'(if5.out_valid), 32'd0);
    checkOutput("hold z_q",       32'(if5.z_q),       32'd1);
    checkOutput("hold count_q",   32'(if5.count_q),   32'd4);
    checkOutput("hold z comb",    32'(if5.z),         32'd0);
    applyStimulus(1'b0, 1'b0, 5'b00000, 7'b0);
    checkOutput("hold2 count_q",  32'(if5.count_q),   32'd4);

    applyStimulus(1'b1, 1'b1, 5'b11111, 7'b1111111);
    checkOutput("rstprio z_q",       32'(if5.z_q),       32'd0);
    checkOutput("rstprio count_q",   32'(if5.count_q),   32'd0);
    checkOutput("rstprio out_valid", 32'(if5.out_valid), 32'd0);

    applyStimulus(1'b0, 1'b1, 5'b11111, 7'b1111111);
    checkOutput("post-rst z_q",       32'(if5.z_q),       32'd1);
    checkOutput("post-rst count_q",   32'(if5.count_q),   32'd5);
    checkOutput("post-rst out_valid", 32'(if5.out_valid), 32'd1);
    checkOutput("thresh4 z 11111",    32'(ifT.z),         32'd1);
    checkOutput("thresh4 z_q 11111",  32'(ifT.z_q),       32'd1);
    checkOutput("thresh4 count_q",    32'(ifT.count_q),   32'd5);
    checkOutput("n7 all ones count",  32'(if7.count_q),   32'd7);

    applyStimulus(1'b0, 1'b1, 5'b00000, 7'b0000111);
    checkOutput("n7 0000111 z",       32'(if7.z),         32'd0);
    checkOutput("n7 0000111 z_q",     32'(if7.z_q),       32'd0);
    checkOutput("n7 0000111 count_q", 32'(if7.count_q),   32'd3);

    applyStimulus(1'b0, 1'b1, 5'b00000, 7'b1001011);
    checkOutput("n7 1001011 z",       32'(if7.z),         32'd1);
    checkOutput("n7 1001011 z_q",     32'(if7.z_q),       32'd1);
    checkOutput("n7 1001011 count_q", 32'(if7.count_q),   32'd4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
